// File: rtl/kanagawa_arb_pkg.sv
// Shared types and helpers for the Kanagawa FIFO read arbiter and its picker.
package kanagawa_arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_CONT,
    GRANT_SCAN
  } grant_kind_e;

  function automatic int src_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/kanagawa_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module kanagawa_rr_pick
  import kanagawa_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  localparam int SRC_W = src_width(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [SRC_W-1:0]       ptr,
  output logic                   grant_valid,
  output logic [SRC_W-1:0]       grant_idx
);

  logic [2*NUM_SOURCES-1:0] req_dbl;
  logic [2*NUM_SOURCES-1:0] req_mask;

  // Upper copy keeps every source eligible, so the wrap falls out of a plain priority encode.
  always_comb begin
    req_dbl = {req, req};
    for (int i = 0; i < 2*NUM_SOURCES; i++) begin
      req_mask[i] = req_dbl[i] && (i >= int'(ptr));
    end
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 2*NUM_SOURCES-1; i >= 0; i--) begin
      if (req_mask[i]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'((i >= NUM_SOURCES) ? i - NUM_SOURCES : i);
      end
    end
  end

endmodule

// File: rtl/kanagawa_fifo_read_arbiter.sv
// Merges several show-ahead FIFO read ports into one registered show-ahead port
// using round-robin arbitration with bounded bursts.
module kanagawa_fifo_read_arbiter
  import kanagawa_arb_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_SOURCES = 4,
  parameter int MAX_BURST   = 1,
  localparam int SRC_W = src_width(NUM_SOURCES)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [NUM_SOURCES-1:0]       rdreq_out,
  input  logic [NUM_SOURCES-1:0]       rdempty_in,
  input  logic [NUM_SOURCES*WIDTH-1:0] rddata_in,
  input  logic                         rdreq_in,
  output logic                         rdempty_out,
  output logic [WIDTH-1:0]             rddata_out,
  output logic [SRC_W-1:0]             rdsrc_out
);

  localparam int PAD_N = 1 << SRC_W;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] last;
  logic [CNT_W-1:0] cnt;

  logic             empty_p0;
  logic [WIDTH-1:0] data_p0;
  logic [SRC_W-1:0] src_p0;

  logic             pop;
  logic             load_ok;
  logic             cont;
  logic             broke;
  logic [NUM_SOURCES-1:0] req;
  logic [PAD_N-1:0] req_pad;
  logic [PAD_N-1:0] grant_oh;
  logic             scan_valid;
  logic [SRC_W-1:0] scan_idx;
  grant_kind_e      kind;
  logic [SRC_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic [CNT_W-1:0] cnt_next;

  kanagawa_rr_pick #(
    .NUM_SOURCES(NUM_SOURCES)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .grant_valid(scan_valid),
    .grant_idx  (scan_idx)
  );

  // Burst continuation wins over the pointer scan while the burst source still has data.
  always_comb begin
    pop     = rdreq_in & ~empty_p0;
    load_ok = empty_p0 | pop;
    req     = ~rdempty_in;
    req_pad = PAD_N'(req);
    cont    = (cnt != '0) && (cnt < BURST_MAX) && req_pad[last];
    kind    = GRANT_NONE;
    grant   = '0;
    if (load_ok && cont) begin
      kind  = GRANT_CONT;
      grant = last;
    end else if (load_ok && scan_valid) begin
      kind  = GRANT_SCAN;
      grant = scan_idx;
    end
    cnt_next = (kind == GRANT_CONT) ? cnt + CNT_W'(1) : CNT_W'(1);
    broke    = (kind == GRANT_SCAN) && (cnt != '0) && (grant != last);
  end

  assign grant_data = rddata_in[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    grant_oh = '0;
    if (!rst && kind != GRANT_NONE) begin
      grant_oh[grant] = 1'b1;
    end
    rdreq_out = NUM_SOURCES'(grant_oh);
  end

  // Stage p0: output register plus arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      empty_p0 <= 1'b1;
      data_p0  <= '0;
      src_p0   <= '0;
      ptr      <= '0;
      cnt      <= '0;
      last     <= '0;
    end else if (kind != GRANT_NONE) begin
      empty_p0 <= 1'b0;
      data_p0  <= grant_data;
      src_p0   <= grant;
      last     <= grant;
      if (cnt_next == BURST_MAX) begin
        ptr <= SRC_W'(wrap_inc(int'(grant), NUM_SOURCES));
        cnt <= '0;
      end else begin
        cnt <= cnt_next;
        if (broke) begin
          ptr <= SRC_W'(wrap_inc(int'(last), NUM_SOURCES));
        end
      end
    end else if (pop) begin
      empty_p0 <= 1'b1;
    end
  end

  assign rdempty_out = empty_p0;
  assign rddata_out  = data_p0;
  assign rdsrc_out   = src_p0;

  assert property (@(posedge clk) disable iff (rst) (rdreq_out & rdempty_in) == '0)
    else $error("rdreq_out asserted for an empty source");

endmodule

// File: tb/tb_kanagawa_fifo_read_arbiter.sv
// Directed bench for kanagawa_fifo_read_arbiter with MAX_BURST=1 and MAX_BURST=3 instances.
module tb_kanagawa_fifo_read_arbiter;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   rdreq_o0, rdreq_o1;
  logic [N-1:0]   rdempty_i0, rdempty_i1;
  logic [N*W-1:0] rddata_i0, rddata_i1;
  logic           rdreq_i0, rdreq_i1;
  logic           rdempty_o0, rdempty_o1;
  logic [W-1:0]   rddata_o0, rddata_o1;
  logic [1:0]     rdsrc_o0, rdsrc_o1;

  kanagawa_fifo_read_arbiter #(.WIDTH(W), .NUM_SOURCES(N), .MAX_BURST(1)) dut_mb1 (
    .clk(clk), .rst(rst), .rdreq_out(rdreq_o0), .rdempty_in(rdempty_i0),
    .rddata_in(rddata_i0), .rdreq_in(rdreq_i0), .rdempty_out(rdempty_o0),
    .rddata_out(rddata_o0), .rdsrc_out(rdsrc_o0));

  kanagawa_fifo_read_arbiter #(.WIDTH(W), .NUM_SOURCES(N), .MAX_BURST(3)) dut_mb3 (
    .clk(clk), .rst(rst), .rdreq_out(rdreq_o1), .rdempty_in(rdempty_i1),
    .rddata_in(rddata_i1), .rdreq_in(rdreq_i1), .rdempty_out(rdempty_o1),
    .rddata_out(rddata_o1), .rdsrc_out(rdsrc_o1));

  // Upstream show-ahead FIFO models: one per source per instance.
  logic [W-1:0] mem [2][N][DEPTH];
  int pushed [2][N];
  int popped [2][N];
  int viol    = 0;
  int pulses1 = 0;
  int tests   = 0;
  int fails   = 0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rdempty_i0[i]       = (pushed[0][i] == popped[0][i]);
      rdempty_i1[i]       = (pushed[1][i] == popped[1][i]);
      rddata_i0[i*W +: W] = mem[0][i][popped[0][i] % DEPTH];
      rddata_i1[i*W +: W] = mem[1][i][popped[1][i] % DEPTH];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rdreq_o0[i]) popped[0][i] <= popped[0][i] + 1;
      if (rdreq_o1[i]) popped[1][i] <= popped[1][i] + 1;
    end
    if (|(rdreq_o0 & rdempty_i0) || |(rdreq_o1 & rdempty_i1)) viol <= viol + 1;
    if (rdreq_o0[1]) pulses1 <= pulses1 + 1;
  end

  task automatic push(input int d, input int s, input logic [W-1:0] w);
    mem[d][s][pushed[d][s] % DEPTH] = w;
    pushed[d][s] = pushed[d][s] + 1;
  endtask

  task automatic flush(input int d);
    for (int i = 0; i < N; i++) pushed[d][i] = popped[d][i];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp_src3 [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
  logic [15:0] exp_dat3 [16] = '{16'h1000, 16'h1001, 16'h1002, 16'h2000, 16'h2001, 16'h2002,
                                 16'h3000, 16'h3001, 16'h3002, 16'h4000, 16'h4001, 16'h4002,
                                 16'h1003, 16'h1004, 16'h1005, 16'h2003};
  int exp_src1 [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  logic [15:0] exp_dat1 [8] = '{16'h2000, 16'h3000, 16'h4000, 16'h1001,
                                16'h2001, 16'h3001, 16'h4001, 16'h1002};
  int p0;

  initial begin
    rdreq_i0 = 1'b0;
    rdreq_i1 = 1'b0;

    // Reset held with all MAX_BURST=1 sources non-empty.
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 8; k++) push(0, s, 16'((s + 1) * 16'h1000 + k));
    repeat (3) begin
      @(negedge clk);
      check("rst_rdreq", 32'(rdreq_o0), 32'h0);
      check("rst_empty", 32'(rdempty_o0), 32'h1);
      check("rst_data", 32'(rddata_o0), 32'h0);
    end
    rst = 1'b0;
    #1;
    check("first_grant_c1", 32'(rdreq_o0), 32'h1);
    check("empty_c1", 32'(rdempty_o0), 32'h1);
    @(negedge clk);
    check("empty_c2", 32'(rdempty_o0), 32'h0);
    check("src_c2", 32'(rdsrc_o0), 32'h0);
    check("data_c2", 32'(rddata_o0), 32'h1000);

    // Continuous reads, plain round robin with wrap from 3 to 0.
    rdreq_i0 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("rr_empty", 32'(rdempty_o0), 32'h0);
      check("rr_src", 32'(rdsrc_o0), 32'(exp_src1[j]));
      check("rr_data", 32'(rddata_o0), 32'(exp_dat1[j]));
    end
    rdreq_i0 = 1'b0;

    // Back-pressure: one word from src1 held for 5 cycles.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_empty", 32'(rdempty_o0), 32'h1);
    flush(0);
    push(0, 1, 16'h0055);
    p0 = pulses1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_empty", 32'(rdempty_o0), 32'h0);
      check("bp_data", 32'(rddata_o0), 32'h55);
      check("bp_src", 32'(rdsrc_o0), 32'h1);
    end
    check("bp_pulses", 32'(pulses1 - p0), 32'h1);
    rdreq_i0 = 1'b1;
    @(negedge clk);
    check("drain_empty", 32'(rdempty_o0), 32'h1);
    check("drain_data_hold", 32'(rddata_o0), 32'h55);
    check("drain_src_hold", 32'(rdsrc_o0), 32'h1);
    rdreq_i0 = 1'b0;

    // MAX_BURST=3 with every source full.
    rst = 1'b1;
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 10; k++) push(1, s, 16'((s + 1) * 16'h1000 + k));
    rdreq_i1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check("burst_empty", 32'(rdempty_o1), 32'h0);
      check("burst_src", 32'(rdsrc_o1), 32'(exp_src3[j]));
      check("burst_data", 32'(rddata_o1), 32'(exp_dat3[j]));
    end

    // Async reset in the middle of the src1 burst.
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_empty", 32'(rdempty_o1), 32'h1);
    check("mid_rst_rdreq", 32'(rdreq_o1), 32'h0);
    check("mid_rst_data", 32'(rddata_o1), 32'h0);
    check("mid_rst_src", 32'(rdsrc_o1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_src0a", 32'(rdsrc_o1), 32'h0);
    check("post_rst_data0a", 32'(rddata_o1), 32'h1006);
    @(negedge clk);
    check("post_rst_data0b", 32'(rddata_o1), 32'h1007);
    @(negedge clk);
    check("post_rst_data0c", 32'(rddata_o1), 32'h1008);
    @(negedge clk);
    check("post_rst_src1", 32'(rdsrc_o1), 32'h1);
    check("post_rst_data1", 32'(rddata_o1), 32'h2004);

    // Burst broken by src0 running dry; pointer then sits at 1.
    rst = 1'b1;
    flush(1);
    push(1, 0, 16'h00A1);
    push(1, 0, 16'h00A2);
    push(1, 2, 16'h00C1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("brk_a1", 32'(rddata_o1), 32'hA1);
    @(negedge clk);
    check("brk_a2", 32'(rddata_o1), 32'hA2);
    check("brk_a2_src", 32'(rdsrc_o1), 32'h0);
    @(negedge clk);
    check("brk_c1", 32'(rddata_o1), 32'hC1);
    check("brk_c1_src", 32'(rdsrc_o1), 32'h2);
    @(negedge clk);
    check("brk_idle_empty", 32'(rdempty_o1), 32'h1);
    check("brk_idle_data", 32'(rddata_o1), 32'hC1);
    check("brk_idle_src", 32'(rdsrc_o1), 32'h2);
    push(1, 0, 16'h0B00);
    push(1, 1, 16'h0B11);
    @(negedge clk);
    check("ptr1_src", 32'(rdsrc_o1), 32'h1);
    check("ptr1_data", 32'(rddata_o1), 32'h0B11);
    @(negedge clk);
    check("ptr1_next_src", 32'(rdsrc_o1), 32'h0);
    check("ptr1_next_data", 32'(rddata_o1), 32'h0B00);
    @(negedge clk);
    check("final_empty", 32'(rdempty_o1), 32'h1);
    rdreq_i1 = 1'b0;

    check("no_pop_of_empty", 32'(viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kanagawa_fifo_read_arbiter.md
Name: kanagawa_fifo_read_arbiter

Overview:
- Merges NUM_SOURCES show-ahead FIFO read ports into one show-ahead read port, using round-robin arbitration with bounded bursts.
- Sits in front of a shared consumer, for example a single pipeline drained from several skid-buffered FIFOs.
- Pops at most one source per cycle into a 1-entry registered output stage, so output data, empty and source tag are all flop-driven.
- Sustains one word per cycle when the consumer reads continuously.

Parameters:
- WIDTH, 16, data width of every source and of the output.
- NUM_SOURCES, 4, number of upstream FIFO read ports; legal range 1..32.
- MAX_BURST, 1, maximum consecutive grants to one source before priority rotates; legal range 1..255.
- SRC_W, derived: $clog2(NUM_SOURCES), forced to a minimum of 1. Not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rdreq_out  out  NUM_SOURCES  per-source pop; one-hot or zero.
- rdempty_in  in  NUM_SOURCES  per-source empty (show-ahead).
- rddata_in  in  NUM_SOURCES*WIDTH  per-source head word; source i occupies bits [i*WIDTH +: WIDTH].
- rdreq_in  in  1  consumer pop.
- rdempty_out  out  1  output stage empty.
- rddata_out  out  WIDTH  output head word.
- rdsrc_out  out  SRC_W  index of the source that supplied rddata_out.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - rdempty_out=1, rddata_out=0, rdsrc_out=0, rdreq_out=0 (combinational, forced 0 while rst=1).
  - Priority pointer ptr=0; burst counter cnt=0; last-grant register last=0.
- Pop of output: pop = rdreq_in & ~rdempty_out. rdreq_in while rdempty_out=1 is ignored and changes no state.
- Load enable: load_ok = rdempty_out | pop.
- Request vector: req[i] = ~rdempty_in[i].
- Grant, combinational:
  - If load_ok=0 or req=0, no grant.
  - Else if cnt>0, cnt<MAX_BURST and req[last]=1: grant=last (burst continuation).
  - Else grant = first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_SOURCES.
- Grant effects, same cycle: rdreq_out[grant]=1; next cycle rddata_out=rddata_in[grant], rdsrc_out=grant, rdempty_out=0.
- No grant but pop: rdempty_out=1 next cycle; rddata_out and rdsrc_out hold their old values.
- Pop and grant in the same cycle: the register is replaced, so throughput is 1/cycle and there is no bubble.
- Latency: source becomes non-empty at edge t, output is idle, rdempty_out=0 after edge t+1.
- Burst and pointer update on each grant g:
  - If g==last and cnt was in a continuation, cnt<=cnt+1; otherwise cnt<=1.
  - last<=g.
  - If the new cnt==MAX_BURST, ptr<=(g+1) mod NUM_SOURCES and cnt<=0.
  - If the grant was a fresh arbitration with MAX_BURST>1, ptr is unchanged until the burst ends.
  - Source empties mid-burst: req[last]=0 falls back to the ptr scan; on grant of a different source, ptr<=(last+1) mod NUM_SOURCES.
- No grant: ptr, cnt and last hold.
- Wrap: ptr=NUM_SOURCES-1 advances to 0. NUM_SOURCES is not required to be a power of two; modulo arithmetic is explicit.
- NUM_SOURCES=1: degenerates to a 1-entry registered buffer; rdsrc_out is always 0.
- Fairness: no requesting source waits more than (NUM_SOURCES-1)*MAX_BURST grants.
- Reset mid-operation: the buffered word is discarded; no rdreq_out pulse is issued during reset. Upstream FIFOs are not touched.
- rdreq_out must never be asserted for a source with rdempty_in=1. This is an assertion.

Decomposition:
- Package kanagawa_arb_pkg:
  - function src_width(n), returning max(1, $clog2(n)).
  - function wrap_inc(idx, n).
- Sub-module kanagawa_rr_pick: combinational masked round-robin picker. Inputs: req and ptr. Outputs: grant_valid and grant index. Implemented as double-width mask/priority-encode; reusable by other arbiters.
- The top level holds the output register, burst counter and pointer state.

Test Plan:
- Reset, N=4: hold rst 3 cycles with all sources non-empty -> rdreq_out=0, rdempty_out=1. First grant after release is src0 at cycle 1; rdempty_out=0 at cycle 2.
- All 4 sources full, MAX_BURST=1, rdreq_in=1 continuously -> rdsrc_out sequence 0,1,2,3,0,1..., one word per cycle, no bubbles.
- MAX_BURST=3, all sources full -> rdsrc_out 0,0,0,1,1,1,2,2,2,3,3,3,0.
- MAX_BURST=3: src0 holds 2 words (0xA1, 0xA2); src2 has 0xC1 -> output A1, A2, C1. ptr is 1 after the src0 burst breaks, and a later request from src1 is granted before src2.
- Back-pressure: rdreq_in=0 for 5 cycles with src1 holding 0x55 -> rdempty_out=0, rddata_out=0x55, rdsrc_out=1 stable; exactly one rdreq_out[1] pulse.
- Async reset asserted mid-burst between clock edges -> rdempty_out=1 immediately, ptr=0; post-release arbitration restarts from src0.
